// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, and redirect tracking across cache refills.
// Latency: PC_OUT is registered; IF/ID captures the hit instruction one cycle after its fetch address is presented.
// Backpressure: HAZARD_STALL freezes PC and IF/ID; ICACHE_BUSYWAIT holds PC and inserts bubbles.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ICACHE_BUSYWAIT,
    input  logic [31:0] ICACHE_INSTR,
    input  logic        HAZARD_STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] PC_OUT,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_INSTR,
    output logic        IFID_VALID,
    output logic        REDIRECT_PENDING,
    output logic [31:0] STALL_CYCLES
);

    typedef enum logic {
        FETCH   = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      state;
    logic [31:0] pending_target;
    logic [31:0] target_aligned;
    logic [31:0] pc_plus4;

    // Masking (rather than slicing) keeps every target bit in use.
    assign target_aligned   = BRANCH_TARGET & ~32'h0000_0003;
    assign pc_plus4         = PC_OUT + 32'd4;
    assign REDIRECT_PENDING = (state == PENDING);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= FETCH;
            PC_OUT         <= RESET_PC;
            pending_target <= 32'h0000_0000;
            IFID_PC        <= 32'h0000_0000;
            IFID_PC4       <= 32'h0000_0000;
            IFID_INSTR     <= NOP_INSTR;
            IFID_VALID     <= 1'b0;
            STALL_CYCLES   <= 32'h0000_0000;
        end else begin
            if (ICACHE_BUSYWAIT && (STALL_CYCLES != 32'hFFFF_FFFF)) begin
                STALL_CYCLES <= STALL_CYCLES + 32'd1;
            end

            case (state)
                FETCH: begin
                    if (BRANCH_TAKEN) begin
                        IFID_VALID <= 1'b0;
                        // The cache is mid-refill on PC_OUT; park the target until it finishes.
                        if (ICACHE_BUSYWAIT) begin
                            pending_target <= target_aligned;
                            state          <= PENDING;
                        end else begin
                            PC_OUT <= target_aligned;
                        end
                    end else if (HAZARD_STALL) begin
                        // Decode needs the current IF/ID contents again; freeze everything.
                    end else if (ICACHE_BUSYWAIT) begin
                        IFID_VALID <= 1'b0;
                    end else begin
                        IFID_PC    <= PC_OUT;
                        IFID_PC4   <= pc_plus4;
                        IFID_INSTR <= ICACHE_INSTR;
                        IFID_VALID <= 1'b1;
                        PC_OUT     <= pc_plus4;
                    end
                end

                PENDING: begin
                    IFID_VALID <= 1'b0;
                    if (BRANCH_TAKEN) begin
                        pending_target <= target_aligned;
                    end
                    if (!ICACHE_BUSYWAIT) begin
                        PC_OUT <= BRANCH_TAKEN ? target_aligned : pending_target;
                        state  <= FETCH;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written reset/wrap sequences,
// and randomized traffic compared against a rule-level model of fetch behaviour.
module tb_if_stage;

    logic        CLK;
    logic        RESET;
    logic        ICACHE_BUSYWAIT;
    logic [31:0] ICACHE_INSTR;
    logic        HAZARD_STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;

    logic [31:0] PC_OUT, IFID_PC, IFID_PC4, IFID_INSTR, STALL_CYCLES;
    logic        IFID_VALID, REDIRECT_PENDING;

    logic [31:0] w_pc_out, w_ifid_pc, w_ifid_pc4, w_ifid_instr, w_stall_cycles;
    logic        w_ifid_valid, w_redirect_pending;

    if_stage dut (
        .CLK(CLK), .RESET(RESET),
        .ICACHE_BUSYWAIT(ICACHE_BUSYWAIT), .ICACHE_INSTR(ICACHE_INSTR),
        .HAZARD_STALL(HAZARD_STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .PC_OUT(PC_OUT), .IFID_PC(IFID_PC), .IFID_PC4(IFID_PC4),
        .IFID_INSTR(IFID_INSTR), .IFID_VALID(IFID_VALID),
        .REDIRECT_PENDING(REDIRECT_PENDING), .STALL_CYCLES(STALL_CYCLES)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .CLK(CLK), .RESET(RESET),
        .ICACHE_BUSYWAIT(ICACHE_BUSYWAIT), .ICACHE_INSTR(ICACHE_INSTR),
        .HAZARD_STALL(HAZARD_STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .PC_OUT(w_pc_out), .IFID_PC(w_ifid_pc), .IFID_PC4(w_ifid_pc4),
        .IFID_INSTR(w_ifid_instr), .IFID_VALID(w_ifid_valid),
        .REDIRECT_PENDING(w_redirect_pending), .STALL_CYCLES(w_stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch stage should hold, tracked as plain variables.
    logic [31:0] m_pc, m_tgt, m_ipc, m_ipc4, m_iinstr, m_stall;
    logic        m_ivalid, m_waiting;

    function automatic void model_reset(input logic [31:0] rpc);
        m_pc = rpc; m_tgt = 0; m_ipc = 0; m_ipc4 = 0;
        m_iinstr = 32'h13; m_ivalid = 0; m_waiting = 0; m_stall = 0;
    endfunction

    function automatic void model_step();
        logic [31:0] t;
        t = BRANCH_TARGET & 32'hFFFF_FFFC;
        if (ICACHE_BUSYWAIT && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (m_waiting) begin
            // Waiting for the refill to end; remember only the newest redirect.
            m_ivalid = 0;
            if (BRANCH_TAKEN) m_tgt = t;
            if (!ICACHE_BUSYWAIT) begin
                m_pc = m_tgt;
                m_waiting = 0;
            end
        end else if (BRANCH_TAKEN) begin
            m_ivalid = 0;
            if (ICACHE_BUSYWAIT) begin m_tgt = t; m_waiting = 1; end
            else m_pc = t;
        end else if (HAZARD_STALL) begin
            m_ivalid = m_ivalid;
        end else if (ICACHE_BUSYWAIT) begin
            m_ivalid = 0;
        end else begin
            m_ipc = m_pc; m_ipc4 = m_pc + 4; m_iinstr = ICACHE_INSTR; m_ivalid = 1;
            m_pc = m_pc + 4;
        end
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, ".pc"},        PC_OUT,           m_pc);
        chk({tag, ".ifid_pc"},   IFID_PC,          m_ipc);
        chk({tag, ".ifid_pc4"},  IFID_PC4,         m_ipc4);
        chk({tag, ".ifid_ins"},  IFID_INSTR,       m_iinstr);
        chk1({tag, ".valid"},    IFID_VALID,       m_ivalid);
        chk1({tag, ".pending"},  REDIRECT_PENDING, m_waiting);
        chk({tag, ".stall"},     STALL_CYCLES,     m_stall);
    endtask

    task automatic drive(input logic busy, input logic haz, input logic br,
                         input logic [31:0] tgt, input logic [31:0] instr);
        ICACHE_BUSYWAIT = busy; HAZARD_STALL = haz; BRANCH_TAKEN = br;
        BRANCH_TARGET = tgt; ICACHE_INSTR = instr;
    endtask

    // Called at a negedge: one rising edge, model advances, return at next negedge.
    task automatic step();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        RESET = 1'b1;
        model_reset(32'h0);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    typedef struct {
        logic        busy, haz, br;
        logic [31:0] tgt, instr;
        logic [31:0] e_pc, e_ifid_pc;
        logic        e_valid, e_pend;
        logic [31:0] e_stall;
    } vec_t;

    vec_t vt [23];

    initial begin
        RESET = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset(32'h0);

        //               busy haz br  tgt           instr         pc            ifid_pc  vld pend stall
        vt[0]  = '{1'b0,1'b0,1'b0,32'h0,   32'h1000_0000,32'h4,  32'h0,  1'b1,1'b0,32'd0};
        vt[1]  = '{1'b0,1'b0,1'b0,32'h0,   32'h1000_0001,32'h8,  32'h4,  1'b1,1'b0,32'd0};
        vt[2]  = '{1'b0,1'b0,1'b0,32'h0,   32'h1000_0002,32'hC,  32'h8,  1'b1,1'b0,32'd0};
        vt[3]  = '{1'b0,1'b0,1'b0,32'h0,   32'h1000_0003,32'h10, 32'hC,  1'b1,1'b0,32'd0};
        vt[4]  = '{1'b1,1'b0,1'b0,32'h0,   32'h1000_0004,32'h10, 32'hC,  1'b0,1'b0,32'd1};
        vt[5]  = '{1'b1,1'b0,1'b0,32'h0,   32'h1000_0004,32'h10, 32'hC,  1'b0,1'b0,32'd2};
        vt[6]  = '{1'b1,1'b0,1'b0,32'h0,   32'h1000_0004,32'h10, 32'hC,  1'b0,1'b0,32'd3};
        vt[7]  = '{1'b1,1'b0,1'b0,32'h0,   32'h1000_0004,32'h10, 32'hC,  1'b0,1'b0,32'd4};
        vt[8]  = '{1'b1,1'b0,1'b0,32'h0,   32'h1000_0004,32'h10, 32'hC,  1'b0,1'b0,32'd5};
        vt[9]  = '{1'b0,1'b0,1'b0,32'h0,   32'h1000_0004,32'h14, 32'h10, 1'b1,1'b0,32'd5};
        vt[10] = '{1'b0,1'b1,1'b0,32'h0,   32'h1000_0005,32'h14, 32'h10, 1'b1,1'b0,32'd5};
        vt[11] = '{1'b1,1'b1,1'b0,32'h0,   32'h1000_0005,32'h14, 32'h10, 1'b1,1'b0,32'd6};
        vt[12] = '{1'b0,1'b1,1'b1,32'h40,  32'h1000_0005,32'h40, 32'h10, 1'b0,1'b0,32'd6};
        vt[13] = '{1'b0,1'b0,1'b1,32'h20,  32'h1000_0005,32'h20, 32'h10, 1'b0,1'b0,32'd6};
        vt[14] = '{1'b1,1'b0,1'b0,32'h0,   32'h1000_0006,32'h20, 32'h10, 1'b0,1'b0,32'd7};
        vt[15] = '{1'b1,1'b0,1'b1,32'h103, 32'h1000_0006,32'h20, 32'h10, 1'b0,1'b1,32'd8};
        vt[16] = '{1'b1,1'b0,1'b0,32'h0,   32'h1000_0006,32'h20, 32'h10, 1'b0,1'b1,32'd9};
        vt[17] = '{1'b1,1'b0,1'b1,32'h200, 32'h1000_0006,32'h20, 32'h10, 1'b0,1'b1,32'd10};
        vt[18] = '{1'b1,1'b1,1'b0,32'h0,   32'h1000_0006,32'h20, 32'h10, 1'b0,1'b1,32'd11};
        vt[19] = '{1'b0,1'b0,1'b0,32'h0,   32'h1000_0006,32'h200,32'h10, 1'b0,1'b0,32'd11};
        vt[20] = '{1'b0,1'b0,1'b0,32'h0,   32'h1000_0007,32'h204,32'h200,1'b1,1'b0,32'd11};
        vt[21] = '{1'b1,1'b0,1'b1,32'h301, 32'h1000_0007,32'h204,32'h200,1'b0,1'b1,32'd12};
        vt[22] = '{1'b0,1'b0,1'b1,32'h405, 32'h1000_0007,32'h404,32'h200,1'b0,1'b0,32'd12};

        @(negedge CLK);
        chk("rst.pc",        PC_OUT,       32'h0);
        chk("rst.ifid_pc",   IFID_PC,      32'h0);
        chk("rst.ifid_pc4",  IFID_PC4,     32'h0);
        chk("rst.ifid_ins",  IFID_INSTR,   32'h0000_0013);
        chk1("rst.valid",    IFID_VALID,   1'b0);
        chk1("rst.pending",  REDIRECT_PENDING, 1'b0);
        chk("rst.stall",     STALL_CYCLES, 32'h0);
        chk("rst.w_pc",      w_pc_out,     32'hFFFF_FFF8);
        RESET = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(vt[i].busy, vt[i].haz, vt[i].br, vt[i].tgt, vt[i].instr);
            step();
            chk($sformatf("vec%0d.pc", i),      PC_OUT,           vt[i].e_pc);
            chk($sformatf("vec%0d.ifid_pc", i), IFID_PC,          vt[i].e_ifid_pc);
            chk1($sformatf("vec%0d.valid", i),  IFID_VALID,       vt[i].e_valid);
            chk1($sformatf("vec%0d.pend", i),   REDIRECT_PENDING, vt[i].e_pend);
            chk($sformatf("vec%0d.stall", i),   STALL_CYCLES,     vt[i].e_stall);
            compare_model($sformatf("vec%0d.m", i));
        end
        chk("vec.instr_i0_slot", IFID_INSTR, 32'h1000_0007);

        // Reset landing between edges while a redirect is pending.
        do_reset();
        drive(1, 0, 1, 32'h80, 32'hDEAD_0000);
        step();
        chk1("arst.pending_before", REDIRECT_PENDING, 1'b1);
        #2 RESET = 1'b1;
        #1;
        chk("arst.pc",        PC_OUT,       32'h0);
        chk1("arst.pending",  REDIRECT_PENDING, 1'b0);
        chk1("arst.valid",    IFID_VALID,   1'b0);
        chk("arst.ifid_ins",  IFID_INSTR,   32'h0000_0013);
        chk("arst.stall",     STALL_CYCLES, 32'h0);
        model_reset(32'h0);
        #1 RESET = 1'b0;
        drive(0, 0, 0, 0, 32'h0BAD_F00D);
        step();
        chk("arst.pc_after",      PC_OUT,  32'h4);
        chk("arst.ifid_pc_after", IFID_PC, 32'h0);
        chk1("arst.pend_after",   REDIRECT_PENDING, 1'b0);
        compare_model("arst.m");

        // Address wrap at the top of the 32-bit space.
        do_reset();
        chk("wrap.pc0", w_pc_out, 32'hFFFF_FFF8);
        drive(0, 0, 0, 0, 32'hAAAA_0001);
        step();
        chk("wrap.pc1", w_pc_out, 32'hFFFF_FFFC);
        chk("wrap.ifid_pc4_1", w_ifid_pc4, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'hAAAA_0002);
        step();
        chk("wrap.pc2", w_pc_out, 32'h0);
        chk("wrap.ifid_pc2", w_ifid_pc, 32'hFFFF_FFFC);
        chk("wrap.ifid_pc4_2", w_ifid_pc4, 32'h0);
        chk("wrap.ifid_ins2", w_ifid_instr, 32'hAAAA_0002);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 12), $urandom, $urandom);
            step();
            compare_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 ICACHE_BUSYWAIT  input  1  instruction cache busy; ICACHE_INSTR invalid while high.
REQ-005 ICACHE_INSTR  input  32  instruction returned by cache for PC_OUT.
REQ-006 HAZARD_STALL  input  1  decode-stage load-use stall request.
REQ-007 BRANCH_TAKEN  input  1  redirect request from execute stage.
REQ-008 BRANCH_TARGET  input  32  redirect address, valid with BRANCH_TAKEN.
REQ-009 PC_OUT  output  32  fetch address to instruction cache ADDR.
REQ-010 IFID_PC  output  32  IF/ID register: PC of held instruction.
REQ-011 IFID_PC4  output  32  IF/ID register: PC+4 of held instruction.
REQ-012 IFID_INSTR  output  32  IF/ID register: instruction.
REQ-013 IFID_VALID  output  1  IF/ID register holds a real instruction; 0 = bubble.
REQ-014 REDIRECT_PENDING  output  1  high while in PENDING state.
REQ-015 STALL_CYCLES  output  32  saturating count of cycles with ICACHE_BUSYWAIT high.

Function
REQ-016 FSM states SHALL be FETCH and PENDING; PC_OUT SHALL be driven directly from the PC register (no combinational path from inputs).
REQ-017 Target alignment: BRANCH_TARGET[1:0] SHALL be forced to 2'b00 whenever loaded into PC or the pending-target register.
REQ-018 PC increment SHALL be PC+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); IFID_PC4 uses the same wrap.
REQ-019 FETCH, BRANCH_TAKEN=1, ICACHE_BUSYWAIT=0: PC <= target; IFID_VALID <= 0; stay FETCH (HAZARD_STALL ignored).
REQ-020 FETCH, BRANCH_TAKEN=1, ICACHE_BUSYWAIT=1: pending target <= target; PC held; IFID_VALID <= 0; go PENDING (PC never changes during a cache refill).
REQ-021 FETCH, no branch, HAZARD_STALL=1: PC and entire IF/ID register (incl. IFID_VALID) held, regardless of ICACHE_BUSYWAIT.
REQ-022 FETCH, no branch, no hazard, ICACHE_BUSYWAIT=1: PC held; IFID_VALID <= 0; other IF/ID fields held.
REQ-023 FETCH, no branch, no hazard, ICACHE_BUSYWAIT=0: IF/ID <= {PC, PC+4, ICACHE_INSTR, 1}; PC <= PC+4; single-cycle throughput on hits.
REQ-024 PENDING: IFID_VALID <= 0 every cycle; HAZARD_STALL ignored; PC held while ICACHE_BUSYWAIT=1.
REQ-025 PENDING, BRANCH_TAKEN=1: newest target SHALL overwrite the pending target (latest redirect wins).
REQ-026 PENDING, ICACHE_BUSYWAIT=0: PC <= BRANCH_TARGET if BRANCH_TAKEN=1 in the same cycle, else pending target; go FETCH.
REQ-027 REDIRECT_PENDING SHALL equal (state == PENDING).
REQ-028 STALL_CYCLES SHALL increment by 1 each rising edge with ICACHE_BUSYWAIT=1, saturating at 32'hFFFF_FFFF, independent of FSM state.

Reset
REQ-029 RESET=1 SHALL asynchronously set PC=RESET_PC, state=FETCH, pending target=0, IFID_PC=0, IFID_PC4=0, IFID_INSTR=32'h0000_0013 (NOP), IFID_VALID=0, STALL_CYCLES=0.
REQ-030 Reset asserted mid-refill or in PENDING SHALL discard the pending redirect; first fetch after release is RESET_PC.

Verification
REQ-031 Reset release, cache always hit, instructions I0..I3 -> PC_OUT 0,4,8,12 on consecutive cycles; IF/ID shows (0,I0,1),(4,I1,1)... one cycle later.
REQ-032 Miss at PC=0x10, BUSYWAIT high 5 cycles -> PC_OUT held 0x10, IFID_VALID=0 for 5 cycles, STALL_CYCLES=5, then (0x10,instr,1).
REQ-033 BRANCH_TAKEN target 0x103 during refill of 0x20, second branch 0x200 two cycles later -> REDIRECT_PENDING=1, PC_OUT stays 0x20 until BUSYWAIT falls, then PC_OUT=0x200; IFID_VALID=0 throughout.
REQ-034 HAZARD_STALL 2 cycles with IF/ID holding (0x8,I2,1) -> IF/ID and PC_OUT=0xC unchanged 2 cycles; branch to 0x40 during stall -> PC_OUT=0x40, IFID_VALID=0 next cycle.
REQ-035 RESET_PC=32'hFFFF_FFF8, hits -> PC_OUT FFFF_FFF8, FFFF_FFFC, 0000_0000; IFID_PC4 of FFFF_FFFC = 0.
REQ-036 RESET asserted in PENDING between clock edges -> outputs immediately at reset values; after release PC_OUT=RESET_PC, REDIRECT_PENDING=0.
